// File: rtl/sim_to_seq_stream_buf_pkg.sv
// Shared sizing helpers and parameter legality check for the
// parallel-to-serial stream buffer.
package sim_to_seq_pkg;

    function automatic int clog2(input int unsigned v);
        int          r;
        int unsigned x;
        r = 0;
        x = 1;
        while (x < v) begin
            x = x << 1;
            r++;
        end
        return r;
    endfunction

    function automatic int nbeats(input int shift_len, input int out_lanes);
        return (out_lanes > 0) ? shift_len / out_lanes : 1;
    endfunction

    function automatic int beat_width(input int shift_len, input int out_lanes);
        int w;
        w = clog2(nbeats(shift_len, out_lanes));
        return (w < 1) ? 1 : w;
    endfunction

    function automatic int eff_distance(input int clk_distance);
        return (clk_distance < 1) ? 1 : clk_distance;
    endfunction

    function automatic bit params_ok(input int bit_width, input int shift_len,
                                     input int out_lanes);
        return (bit_width >= 1) && (shift_len >= 1) && (out_lanes >= 1) &&
               ((shift_len % out_lanes) == 0);
    endfunction

endpackage

// File: rtl/sim_to_seq_stream_buf_if.sv
// Word-in / beat-out handshake bundle; master drives words and accepts beats.
interface sim_to_seq_stream_buf_if
    import sim_to_seq_pkg::*;
#(
    parameter int BIT_WIDTH = 2,
    parameter int SHIFT_LEN = 8,
    parameter int OUT_LANES = 1
);
    localparam int BEAT_W = beat_width(SHIFT_LEN, OUT_LANES);

    logic                           in_valid;
    logic                           in_ready;
    logic [BIT_WIDTH*SHIFT_LEN-1:0] in;
    logic                           out_valid;
    logic                           out_ready;
    logic [BIT_WIDTH*OUT_LANES-1:0] out;
    logic                           out_last;
    logic [BEAT_W-1:0]              out_beat;
    logic                           busy;

    modport master (
        output in_valid, in, out_ready,
        input  in_ready, out_valid, out, out_last, out_beat, busy
    );

    modport slave (
        input  in_valid, in, out_ready,
        output in_ready, out_valid, out, out_last, out_beat, busy
    );
endinterface

// File: rtl/sim_to_seq_stream_buf_pacer.sv
// Saturating beat-spacing counter; constant ready when no spacing is needed.
module clk_distance_pacer
    import sim_to_seq_pkg::*;
#(
    parameter int CLK_DISTANCE = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    input  logic active,
    output logic pace_done
);
    localparam int DIST = eff_distance(CLK_DISTANCE);

    generate
        if (DIST == 1) begin : g_bypass
            logic unused_bypass;
            assign unused_bypass = ^{clk, rst, en, clr, active};
            assign pace_done     = 1'b1;
        end else begin : g_count
            localparam int            CW  = clog2(DIST);
            localparam logic [CW-1:0] TOP = CW'(DIST - 1);

            logic [CW-1:0] count_q, count_d;

            always_comb begin
                count_d = count_q;
                if (en) begin
                    if (clr)
                        count_d = '0;
                    else if (active && (count_q != TOP))
                        count_d = count_q + CW'(1);
                end
            end

            always_ff @(posedge clk) begin
                if (rst) count_q <= '0;
                else     count_q <= count_d;
            end

            assign pace_done = (count_q == TOP);
        end
    endgenerate
endmodule

// File: rtl/sim_to_seq_stream_buf.sv
// Parallel-to-serial converter: whole words in, OUT_LANES-element beats out,
// with a shadow slot so consecutive words stream without bubbles.
module sim_to_seq_stream_buf
    import sim_to_seq_pkg::*;
#(
    parameter int BIT_WIDTH    = 2,
    parameter int SHIFT_LEN    = 8,
    parameter int OUT_LANES    = 1,
    parameter int DIRECTION    = 1,
    parameter int CLK_DISTANCE = 1
) (
    input  logic                    clk,
    input  logic                    in_ctr_Srst,
    input  logic                    in_ctr_en,
    sim_to_seq_stream_buf_if.slave  io
);
    localparam int                NB        = nbeats(SHIFT_LEN, OUT_LANES);
    localparam int                BEAT_W    = beat_width(SHIFT_LEN, OUT_LANES);
    localparam int                WORD_W    = BIT_WIDTH * SHIFT_LEN;
    localparam int                BEAT_BITS = BIT_WIDTH * OUT_LANES;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NB - 1);

    generate
        if (!params_ok(BIT_WIDTH, SHIFT_LEN, OUT_LANES)) begin : g_bad_params
            $error("sim_to_seq_stream_buf: OUT_LANES must divide SHIFT_LEN");
        end
    endgenerate

    logic [WORD_W-1:0] active_q, active_d, shadow_q, shadow_d, word_ord;
    logic              act_full_q, act_full_d, sh_full_q, sh_full_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic              in_xfer, out_xfer, last_xfer, load_direct, load_active;
    logic              pace_done, pace_clr;

    // Words are stored pre-permuted into emission order so the head beat is
    // always the low BEAT_BITS and each beat is a plain right shift.
    always_comb begin
        word_ord = '0;
        for (int unsigned n = 0; n < SHIFT_LEN; n++) begin
            if (DIRECTION > 0)
                word_ord[n*BIT_WIDTH +: BIT_WIDTH] = io.in[(SHIFT_LEN-1-n)*BIT_WIDTH +: BIT_WIDTH];
            else
                word_ord[n*BIT_WIDTH +: BIT_WIDTH] = io.in[n*BIT_WIDTH +: BIT_WIDTH];
        end
    end

    assign io.in_ready  = in_ctr_en & ~sh_full_q;
    assign io.out_valid = in_ctr_en & act_full_q & pace_done;

    assign in_xfer     = io.in_valid & io.in_ready;
    assign out_xfer    = io.out_valid & io.out_ready;
    assign last_xfer   = out_xfer & (beat_q == LAST_BEAT);
    assign load_direct = in_xfer & (~act_full_q | last_xfer);
    assign load_active = load_direct | (last_xfer & sh_full_q);
    assign pace_clr    = load_active | out_xfer;

    always_comb begin
        active_d   = active_q;
        shadow_d   = shadow_q;
        act_full_d = act_full_q;
        sh_full_d  = sh_full_q;
        beat_d     = beat_q;

        if (out_xfer) begin
            active_d = active_q >> BEAT_BITS;
            beat_d   = last_xfer ? '0 : beat_q + BEAT_W'(1);
        end

        if (last_xfer) begin
            if (sh_full_q) begin
                active_d  = shadow_q;
                sh_full_d = 1'b0;
            end else begin
                act_full_d = 1'b0;
            end
        end

        if (in_xfer) begin
            if (load_direct) begin
                active_d   = word_ord;
                act_full_d = 1'b1;
                beat_d     = '0;
            end else begin
                shadow_d  = word_ord;
                sh_full_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (in_ctr_Srst) begin
            active_q   <= '0;
            shadow_q   <= '0;
            act_full_q <= 1'b0;
            sh_full_q  <= 1'b0;
            beat_q     <= '0;
        end else begin
            active_q   <= active_d;
            shadow_q   <= shadow_d;
            act_full_q <= act_full_d;
            sh_full_q  <= sh_full_d;
            beat_q     <= beat_d;
        end
    end

    clk_distance_pacer #(
        .CLK_DISTANCE (CLK_DISTANCE)
    ) u_pacer (
        .clk       (clk),
        .rst       (in_ctr_Srst),
        .en        (in_ctr_en),
        .clr       (pace_clr),
        .active    (act_full_q),
        .pace_done (pace_done)
    );

    assign io.out      = active_q[BEAT_BITS-1:0];
    assign io.out_last = (beat_q == LAST_BEAT);
    assign io.out_beat = beat_q;
    assign io.busy     = act_full_q | sh_full_q;
endmodule

// File: tb/tb_sim_to_seq_stream_buf.sv
// Scoreboard bench: three configurations (MSB-first x1, LSB-first x2, paced x1).
module tb_sim_to_seq_stream_buf;
    logic clk = 1'b0;
    logic rst;
    logic en;

    always #5 clk = ~clk;

    sim_to_seq_stream_buf_if #(.BIT_WIDTH(4), .SHIFT_LEN(8), .OUT_LANES(1)) ifa ();
    sim_to_seq_stream_buf_if #(.BIT_WIDTH(4), .SHIFT_LEN(8), .OUT_LANES(2)) ifb ();
    sim_to_seq_stream_buf_if #(.BIT_WIDTH(4), .SHIFT_LEN(8), .OUT_LANES(1)) ifc ();

    sim_to_seq_stream_buf #(
        .BIT_WIDTH(4), .SHIFT_LEN(8), .OUT_LANES(1), .DIRECTION(1), .CLK_DISTANCE(1)
    ) dut_a (.clk(clk), .in_ctr_Srst(rst), .in_ctr_en(en), .io(ifa));

    sim_to_seq_stream_buf #(
        .BIT_WIDTH(4), .SHIFT_LEN(8), .OUT_LANES(2), .DIRECTION(0), .CLK_DISTANCE(1)
    ) dut_b (.clk(clk), .in_ctr_Srst(rst), .in_ctr_en(en), .io(ifb));

    sim_to_seq_stream_buf #(
        .BIT_WIDTH(4), .SHIFT_LEN(8), .OUT_LANES(1), .DIRECTION(1), .CLK_DISTANCE(3)
    ) dut_c (.clk(clk), .in_ctr_Srst(rst), .in_ctr_en(en), .io(ifc));

    typedef struct {
        logic [15:0] d;
        int          beat;
        bit          last;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    exp_t qc[$];

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    endtask

    task automatic push(input int which, input logic [15:0] d, input int beat, input bit last);
        exp_t e;
        e.d    = d;
        e.beat = beat;
        e.last = last;
        case (which)
            0:       qa.push_back(e);
            1:       qb.push_back(e);
            default: qc.push_back(e);
        endcase
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitors: every accepted beat must match the head of its scoreboard queue
    always @(negedge clk) begin
        exp_t e;
        if (ifa.out_valid && ifa.out_ready) begin
            if (qa.size() == 0) begin
                n_total++;
                $display("FAIL A_unexpected_beat: got out=%0h beat=%0d expected no beat", ifa.out, ifa.out_beat);
            end else begin
                e = qa.pop_front();
                chk("A_out", 32'(ifa.out), 32'(e.d));
                chk("A_beat", 32'(ifa.out_beat), 32'(e.beat));
                chk("A_last", 32'(ifa.out_last), 32'(e.last));
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (ifb.out_valid && ifb.out_ready) begin
            if (qb.size() == 0) begin
                n_total++;
                $display("FAIL B_unexpected_beat: got out=%0h beat=%0d expected no beat", ifb.out, ifb.out_beat);
            end else begin
                e = qb.pop_front();
                chk("B_out", 32'(ifb.out), 32'(e.d));
                chk("B_beat", 32'(ifb.out_beat), 32'(e.beat));
                chk("B_last", 32'(ifb.out_last), 32'(e.last));
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (ifc.out_valid && ifc.out_ready) begin
            if (qc.size() == 0) begin
                n_total++;
                $display("FAIL C_unexpected_beat: got out=%0h beat=%0d expected no beat", ifc.out, ifc.out_beat);
            end else begin
                e = qc.pop_front();
                chk("C_out", 32'(ifc.out), 32'(e.d));
                chk("C_beat", 32'(ifc.out_beat), 32'(e.beat));
                chk("C_last", 32'(ifc.out_last), 32'(e.last));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic exp_v;

        rst = 1'b1;
        en  = 1'b1;
        ifa.in_valid = 1'b0; ifa.in = '0; ifa.out_ready = 1'b1;
        ifb.in_valid = 1'b0; ifb.in = '0; ifb.out_ready = 1'b1;
        ifc.in_valid = 1'b0; ifc.in = '0; ifc.out_ready = 1'b1;
        repeat (2) tick();

        @(negedge clk);
        chk("rst_A_valid", 32'(ifa.out_valid), 0);
        chk("rst_A_out", 32'(ifa.out), 0);
        chk("rst_A_last", 32'(ifa.out_last), 0);
        chk("rst_A_beat", 32'(ifa.out_beat), 0);
        chk("rst_A_busy", 32'(ifa.busy), 0);
        chk("rst_A_in_ready", 32'(ifa.in_ready), 1);
        chk("rst_B_last", 32'(ifb.out_last), 0);
        chk("rst_C_busy", 32'(ifc.busy), 0);
        tick();
        rst = 1'b0;

        // A: single word, MSB element first
        ifa.in = 32'h7654_3210;
        ifa.in_valid = 1'b1;
        for (int k = 0; k < 8; k++) push(0, 16'(7 - k), k, k == 7);
        @(negedge clk);
        chk("A_pre_valid", 32'(ifa.out_valid), 0);
        chk("A_pre_in_ready", 32'(ifa.in_ready), 1);
        tick();
        ifa.in_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("A_stream_valid", 32'(ifa.out_valid), 1);
            tick();
        end
        @(negedge clk);
        chk("A_idle_valid", 32'(ifa.out_valid), 0);
        chk("A_idle_busy", 32'(ifa.busy), 0);
        chk("A_idle_out", 32'(ifa.out), 0);
        tick();

        // B: two lanes, element 0 first
        ifb.in = 32'h7654_3210;
        ifb.in_valid = 1'b1;
        push(1, 16'h10, 0, 0);
        push(1, 16'h32, 1, 0);
        push(1, 16'h54, 2, 0);
        push(1, 16'h76, 3, 1);
        tick();
        ifb.in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("B_stream_valid", 32'(ifb.out_valid), 1);
            tick();
        end
        @(negedge clk);
        chk("B_idle_busy", 32'(ifb.busy), 0);
        chk("B_idle_out", 32'(ifb.out), 0);
        tick();

        // A: two words back to back, 16 contiguous beats
        ifa.in = 32'h7654_3210;
        ifa.in_valid = 1'b1;
        for (int k = 0; k < 8; k++) push(0, 16'(7 - k), k, k == 7);
        for (int k = 0; k < 8; k++) push(0, 16'(15 - k), k, k == 7);
        tick();
        ifa.in = 32'hFEDC_BA98;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            chk("A_b2b_valid", 32'(ifa.out_valid), 1);
            chk("A_b2b_in_ready", 32'(ifa.in_ready), 32'(i == 0 || i >= 8));
            chk("A_b2b_busy", 32'(ifa.busy), 1);
            tick();
            if (i == 0) ifa.in_valid = 1'b0;
        end
        @(negedge clk);
        chk("A_b2b_busy_end", 32'(ifa.busy), 0);
        chk("A_b2b_valid_end", 32'(ifa.out_valid), 0);
        tick();

        // C: paced every 3rd cycle, with 5 cycles of back-pressure on beat 2
        ifc.in = 32'h7654_3210;
        ifc.in_valid = 1'b1;
        for (int k = 0; k < 8; k++) push(2, 16'(7 - k), k, k == 7);
        tick();
        ifc.in_valid = 1'b0;
        for (int i = 0; i < 28; i++) begin
            @(negedge clk);
            if (i < 6)       exp_v = (i % 3 == 2);
            else if (i < 11) exp_v = (i >= 8);
            else if (i == 11) exp_v = 1'b1;
            else             exp_v = ((i - 11) % 3 == 0) && (i <= 26);
            chk("C_pace_valid", 32'(ifc.out_valid), 32'(exp_v));
            if (i >= 6 && i <= 11) begin
                chk("C_hold_out", 32'(ifc.out), 32'h5);
                chk("C_hold_beat", 32'(ifc.out_beat), 2);
            end
            tick();
            if (i == 5)  ifc.out_ready = 1'b0;
            if (i == 10) ifc.out_ready = 1'b1;
        end
        @(negedge clk);
        chk("C_idle_busy", 32'(ifc.busy), 0);
        tick();

        // A: enable low for 4 cycles after beat 2
        ifa.in = 32'h7654_3210;
        ifa.in_valid = 1'b1;
        for (int k = 0; k < 8; k++) push(0, 16'(7 - k), k, k == 7);
        tick();
        ifa.in_valid = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (i >= 3 && i <= 6) begin
                chk("A_en_low_valid", 32'(ifa.out_valid), 0);
                chk("A_en_low_in_ready", 32'(ifa.in_ready), 0);
                chk("A_en_low_beat", 32'(ifa.out_beat), 3);
            end else begin
                chk("A_en_valid", 32'(ifa.out_valid), 1);
                chk("A_en_beat", 32'(ifa.out_beat), (i < 3) ? i : i - 4);
            end
            tick();
            if (i == 2) en = 1'b0;
            if (i == 6) en = 1'b1;
        end
        @(negedge clk);
        chk("A_en_busy_end", 32'(ifa.busy), 0);
        tick();

        // A: reset after beat 3 with the shadow slot full
        ifa.in = 32'h7654_3210;
        ifa.in_valid = 1'b1;
        for (int k = 0; k < 4; k++) push(0, 16'(7 - k), k, 1'b0);
        tick();
        ifa.in = 32'hFEDC_BA98;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("A_pre_rst_valid", 32'(ifa.out_valid), 1);
            tick();
            if (i == 0) ifa.in_valid = 1'b0;
        end
        rst = 1'b1;
        ifa.out_ready = 1'b0;
        @(negedge clk);
        chk("A_pre_rst_shadow", 32'(ifa.in_ready), 0);
        tick();
        rst = 1'b0;
        ifa.out_ready = 1'b1;
        @(negedge clk);
        chk("A_post_rst_valid", 32'(ifa.out_valid), 0);
        chk("A_post_rst_busy", 32'(ifa.busy), 0);
        chk("A_post_rst_out", 32'(ifa.out), 0);
        chk("A_post_rst_beat", 32'(ifa.out_beat), 0);
        chk("A_post_rst_in_ready", 32'(ifa.in_ready), 1);
        tick();
        ifa.in = 32'h89AB_CDEF;
        ifa.in_valid = 1'b1;
        for (int k = 0; k < 8; k++) push(0, 16'(8 + k), k, k == 7);
        tick();
        ifa.in_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("A_new_valid", 32'(ifa.out_valid), 1);
            chk("A_new_beat", 32'(ifa.out_beat), i);
            tick();
        end

        repeat (3) tick();
        chk("A_queue_drained", 32'(qa.size()), 0);
        chk("B_queue_drained", 32'(qb.size()), 0);
        chk("C_queue_drained", 32'(qc.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
